motor_nn_sequencer: RTL and testbench

Control-loop sequencer placed directly upstream of `motor_main`, the W16Q7 neural-network controller wrapper. Every `PERIOD` cycles of `clk_1` it samples the raw sensor and reference words and converts them to saturated Q7. It then fires a single-cycle `ap_start` / `fc0_input_ap_vld` pulse into `motor_main` and waits for `ap_done`. It captures `layer13_out`, clamps it to actuator limits, and publishes it as `u_cmd`, with overrun and timeout supervision.

---
 rtl/motor_nn_sequencer_if.sv | 30 +++
 rtl/motor_nn_sequencer.sv | 175 +++++++++++++++++
 tb/tb_motor_nn_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_nn_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// motor_nn_sequencer_if
// Handshake/operand bundle between the control-loop sequencer and motor_main.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface motor_nn_sequencer_if;
  logic signed [15:0] r;
  logic signed [15:0] pos;
  logic signed [15:0] vel;
  logic               ap_start;
  logic               fc0_input_ap_vld;
  logic               ap_done;
  logic               ap_idle;
  logic signed [15:0] layer13_out;
  logic               layer13_out_ap_vld;

  // Sequencer side: drives operands and start, observes completion.
  modport master (
    output r, pos, vel, ap_start, fc0_input_ap_vld,
    input  ap_done, ap_idle, layer13_out, layer13_out_ap_vld
  );

  // Network side: consumes operands and start, reports completion.
  modport slave (
    input  r, pos, vel, ap_start, fc0_input_ap_vld,
    output ap_done, ap_idle, layer13_out, layer13_out_ap_vld
  );
endinterface
`default_nettype wire

// File: rtl/motor_nn_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// motor_nn_sequencer
// Periodic launcher for the W16Q7 network: samples Q16.16 sensor words,
// saturates them to Q7, starts motor_main, clamps its result into u_cmd,
// and supervises overrun and timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
module motor_nn_sequencer #(
  parameter int                 PERIOD  = 1000,
  parameter int                 TIMEOUT = 200,
  parameter logic signed [15:0] U_MAX   = 16'sd1280,
  parameter logic signed [15:0] U_MIN   = -16'sd1280
) (
  input  logic                 clk_1,
  input  logic                 ap_rst,
  input  logic                 enable,
  input  logic                 clear_flags,
  input  logic signed [31:0]   r_raw,
  input  logic signed [31:0]   pos_raw,
  input  logic signed [31:0]   vel_raw,
  motor_nn_sequencer_if.master nn,
  output logic signed [15:0]   u_cmd,
  output logic                 u_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout,
  output logic [7:0]           skip_cnt
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      period_cnt;
  logic [TW-1:0]      to_cnt;
  logic [TW-1:0]      to_cnt_next;
  logic               tick;
  logic               overrun_evt;
  logic               vld_seen;
  logic signed [15:0] result;
  logic signed [15:0] final_result;

  // Q16.16 -> Q7: floor shift by 9, then saturate to the 16-bit signed range.
  function automatic logic signed [15:0] to_q7(input logic signed [31:0] raw);
    logic signed [31:0] sh;
    sh = raw >>> 9;
    if (sh > 32'sd32767)
      return 16'h7FFF;
    else if (sh < -32'sd32768)
      return 16'h8000;
    else
      return sh[15:0];
  endfunction

  // Actuator limit clamp.
  function automatic logic signed [15:0] clamp_u(input logic signed [15:0] v);
    if (v > U_MAX)
      return U_MAX;
    else if (v < U_MIN)
      return U_MIN;
    else
      return v;
  endfunction

  assign tick         = enable && (period_cnt == CW'(PERIOD - 1));
  // Any tick we cannot act on: the network is still working or not yet idle.
  assign overrun_evt  = tick && ((state != S_IDLE) || !nn.ap_idle);
  // Counter value after this BUSY cycle; it equals the number of BUSY cycles spent.
  assign to_cnt_next  = to_cnt + TW'(1);
  // A result seen with vld takes precedence over whatever is on the bus at done.
  assign final_result = vld_seen ? result : nn.layer13_out;

  // Free-running control-period counter, held at zero while disabled.
  always_ff @(posedge clk_1 or posedge ap_rst) begin
    if (ap_rst)
      period_cnt <= '0;
    else if (!enable || tick)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + CW'(1);
  end

  // Sequencer FSM with registered operands, handshake, command and flags.
  always_ff @(posedge clk_1 or posedge ap_rst) begin
    if (ap_rst) begin
      state               <= S_IDLE;
      to_cnt              <= '0;
      vld_seen            <= 1'b0;
      result              <= '0;
      nn.r                <= '0;
      nn.pos              <= '0;
      nn.vel              <= '0;
      nn.ap_start         <= 1'b0;
      nn.fc0_input_ap_vld <= 1'b0;
      u_cmd               <= '0;
      u_valid             <= 1'b0;
      busy                <= 1'b0;
      overrun             <= 1'b0;
      timeout             <= 1'b0;
      skip_cnt            <= '0;
    end else begin
      u_valid             <= 1'b0;
      nn.ap_start         <= 1'b0;
      nn.fc0_input_ap_vld <= 1'b0;

      // Clear first so that a same-cycle set event below overrides it.
      if (clear_flags) begin
        overrun  <= 1'b0;
        timeout  <= 1'b0;
        skip_cnt <= '0;
      end

      if (overrun_evt) begin
        overrun <= 1'b1;
        if (skip_cnt != 8'hFF)
          skip_cnt <= skip_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (tick && nn.ap_idle) begin
            nn.r                <= to_q7(r_raw);
            nn.pos              <= to_q7(pos_raw);
            nn.vel              <= to_q7(vel_raw);
            nn.ap_start         <= 1'b1;
            nn.fc0_input_ap_vld <= 1'b1;
            busy                <= 1'b1;
            state               <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          to_cnt   <= '0;
          vld_seen <= 1'b0;
          state    <= S_BUSY;
        end

        S_BUSY: begin
          to_cnt <= to_cnt_next;
          if (nn.layer13_out_ap_vld && !vld_seen) begin
            result   <= nn.layer13_out;
            vld_seen <= 1'b1;
          end
          if (nn.ap_done) begin
            u_cmd   <= clamp_u(final_result);
            u_valid <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (to_cnt_next == TW'(TIMEOUT)) begin
            // Abort to a safe zero command.
            timeout <= 1'b1;
            u_cmd   <= '0;
            u_valid <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_nn_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_motor_nn_sequencer
// Directed bench: conversion, launch timing, clamping, timeout, overrun,
// flag clearing and mid-flight reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_motor_nn_sequencer;

  logic               clk_1;
  logic               ap_rst;
  logic               enable, enable2;
  logic               clear_flags, clear_flags2;
  logic [31:0]        r_raw, pos_raw, vel_raw;
  logic signed [15:0] u_cmd, u_cmd2;
  logic               u_valid, u_valid2;
  logic               busy, busy2;
  logic               overrun, overrun2;
  logic               timeout, timeout2;
  logic [7:0]         skip_cnt, skip_cnt2;

  int checks   = 0;
  int failures = 0;

  motor_nn_sequencer_if bus1 ();
  motor_nn_sequencer_if bus2 ();

  motor_nn_sequencer #(.PERIOD(20), .TIMEOUT(8)) u_dut (
    .clk_1       (clk_1),
    .ap_rst      (ap_rst),
    .enable      (enable),
    .clear_flags (clear_flags),
    .r_raw       (r_raw),
    .pos_raw     (pos_raw),
    .vel_raw     (vel_raw),
    .nn          (bus1.master),
    .u_cmd       (u_cmd),
    .u_valid     (u_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout     (timeout),
    .skip_cnt    (skip_cnt)
  );

  motor_nn_sequencer #(.PERIOD(20), .TIMEOUT(50)) u_dut2 (
    .clk_1       (clk_1),
    .ap_rst      (ap_rst),
    .enable      (enable2),
    .clear_flags (clear_flags2),
    .r_raw       (r_raw),
    .pos_raw     (pos_raw),
    .vel_raw     (vel_raw),
    .nn          (bus2.master),
    .u_cmd       (u_cmd2),
    .u_valid     (u_valid2),
    .busy        (busy2),
    .overrun     (overrun2),
    .timeout     (timeout2),
    .skip_cnt    (skip_cnt2)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to the negedge on which DUT1's ap_start is visible, bounded.
  task automatic wait_start1(input string tag);
    int n;
    n = 0;
    while (bus1.ap_start !== 1'b1 && n < 60) begin
      @(negedge clk_1);
      n++;
    end
    chk1(tag, bus1.ap_start, 1'b1);
  endtask

  // Hard stop if something stalls far beyond the expected run length.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    ap_rst = 1'b1; enable = 1'b0; enable2 = 1'b0;
    clear_flags = 1'b0; clear_flags2 = 1'b0;
    r_raw = '0; pos_raw = '0; vel_raw = '0;
    bus1.ap_done = 1'b0; bus1.ap_idle = 1'b1; bus1.layer13_out = '0; bus1.layer13_out_ap_vld = 1'b0;
    bus2.ap_done = 1'b0; bus2.ap_idle = 1'b1; bus2.layer13_out = '0; bus2.layer13_out_ap_vld = 1'b0;
    repeat (3) @(negedge clk_1);
    ap_rst = 1'b0;
    @(negedge clk_1);

    // Reset state
    chk16("rst_r", bus1.r, 16'h0000);
    chk16("rst_pos", bus1.pos, 16'h0000);
    chk16("rst_vel", bus1.vel, 16'h0000);
    chk16("rst_u_cmd", u_cmd, 16'h0000);
    chk1("rst_u_valid", u_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ap_start", bus1.ap_start, 1'b0);
    chk1("rst_fc0_vld", bus1.fc0_input_ap_vld, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk16("rst_skip", 16'(skip_cnt), 16'h0000);

    // T1: conversion and exact launch timing; vld before done
    r_raw = 32'h0001_8000; pos_raw = 32'h0000_0000; vel_raw = 32'hFFFF_0000;
    enable = 1'b1;
    repeat (19) @(negedge clk_1);
    chk1("t1_no_early_start", bus1.ap_start, 1'b0);
    @(negedge clk_1);
    chk1("t1_start", bus1.ap_start, 1'b1);
    chk1("t1_fc0_vld", bus1.fc0_input_ap_vld, 1'b1);
    chk16("t1_r", bus1.r, 16'h00C0);
    chk16("t1_pos", bus1.pos, 16'h0000);
    chk16("t1_vel", bus1.vel, 16'hFF80);
    chk1("t1_busy", busy, 1'b1);
    @(negedge clk_1);
    chk1("t1_start_one_cycle", bus1.ap_start, 1'b0);
    chk1("t1_vld_one_cycle", bus1.fc0_input_ap_vld, 1'b0);
    r_raw = 32'h7FFF_FFFF;
    bus1.layer13_out = 16'sd2000; bus1.layer13_out_ap_vld = 1'b1;
    @(negedge clk_1);
    chk16("t1_r_held", bus1.r, 16'h00C0);
    bus1.layer13_out_ap_vld = 1'b0; bus1.layer13_out = 16'sd5; bus1.ap_done = 1'b1;
    chk1("t1_no_uvalid_yet", u_valid, 1'b0);
    @(negedge clk_1);
    bus1.ap_done = 1'b0;
    chk1("t1_uvalid", u_valid, 1'b1);
    chk16("t1_u_cmd_clamp_hi", u_cmd, 16'd1280);
    chk1("t1_busy_low", busy, 1'b0);
    @(negedge clk_1);
    chk1("t1_uvalid_one_cycle", u_valid, 1'b0);
    chk16("t1_u_cmd_hold", u_cmd, 16'd1280);

    // T2: positive saturation, floor of -1; done during LAUNCH ignored
    pos_raw = 32'h0040_0000; vel_raw = 32'hFFFF_FFFF;
    wait_start1("t2_start");
    chk16("t2_r_sat_hi", bus1.r, 16'h7FFF);
    chk16("t2_pos", bus1.pos, 16'h2000);
    chk16("t2_vel_floor", bus1.vel, 16'hFFFF);
    bus1.layer13_out = -16'sd2000; bus1.ap_done = 1'b1;
    @(negedge clk_1);
    chk1("t2_done_in_launch_ignored", u_valid, 1'b0);
    chk1("t2_still_busy", busy, 1'b1);
    @(negedge clk_1);
    bus1.ap_done = 1'b0;
    chk1("t2_uvalid", u_valid, 1'b1);
    chk16("t2_u_cmd_clamp_lo", u_cmd, 16'hFB00);

    // T3: negative saturation; vld and done together, in range
    r_raw = 32'h8000_0000; pos_raw = 32'hFFFF_FFFF; vel_raw = 32'h0000_01FF;
    wait_start1("t3_start");
    chk16("t3_r_sat_lo", bus1.r, 16'h8000);
    chk16("t3_pos", bus1.pos, 16'hFFFF);
    chk16("t3_vel", bus1.vel, 16'h0000);
    @(negedge clk_1);
    bus1.layer13_out = 16'sd300; bus1.layer13_out_ap_vld = 1'b1; bus1.ap_done = 1'b1;
    @(negedge clk_1);
    bus1.layer13_out_ap_vld = 1'b0; bus1.ap_done = 1'b0;
    chk16("t3_u_cmd", u_cmd, 16'd300);
    chk1("t3_uvalid", u_valid, 1'b1);

    // T4: no done -> timeout after 8 BUSY cycles
    r_raw = 32'h0000_0200; pos_raw = '0; vel_raw = '0;
    wait_start1("t4_start");
    repeat (8) @(negedge clk_1);
    chk1("t4_busy_before_limit", busy, 1'b1);
    chk1("t4_no_timeout_yet", timeout, 1'b0);
    @(negedge clk_1);
    chk1("t4_timeout", timeout, 1'b1);
    chk1("t4_uvalid", u_valid, 1'b1);
    chk16("t4_u_cmd_safe", u_cmd, 16'h0000);
    chk1("t4_busy_low", busy, 1'b0);
    @(negedge clk_1);
    chk1("t4_uvalid_one_cycle", u_valid, 1'b0);
    chk1("t4_timeout_sticky", timeout, 1'b1);

    // T5: next tick relaunches, exactly one period after the previous launch
    repeat (9) @(negedge clk_1);
    chk1("t5_no_early_start", bus1.ap_start, 1'b0);
    @(negedge clk_1);
    chk1("t5_relaunch", bus1.ap_start, 1'b1);
    chk16("t5_r", bus1.r, 16'h0001);
    @(negedge clk_1);
    bus1.layer13_out = 16'sd77; bus1.ap_done = 1'b1;
    @(negedge clk_1);
    bus1.ap_done = 1'b0;
    chk16("t5_u_cmd", u_cmd, 16'd77);

    // T6: tick while network not idle -> overrun, no launch, operands held
    bus1.ap_idle = 1'b0;
    r_raw = 32'h0010_0000;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1);
      if (bus1.ap_start === 1'b1) seen = 1'b1;
    end
    chk1("t6_no_launch", seen, 1'b0);
    chk1("t6_overrun", overrun, 1'b1);
    chk16("t6_skip", 16'(skip_cnt), 16'd1);
    chk16("t6_r_held", bus1.r, 16'h0001);
    clear_flags = 1'b1;
    @(negedge clk_1);
    clear_flags = 1'b0;
    chk1("t6_overrun_clr", overrun, 1'b0);
    chk1("t6_timeout_clr", timeout, 1'b0);
    chk16("t6_skip_clr", 16'(skip_cnt), 16'd0);
    bus1.ap_idle = 1'b1;
    enable = 1'b0;

    // T7: second instance, TIMEOUT=50, slow network -> tick during BUSY
    enable2 = 1'b1;
    n = 0;
    while (bus2.ap_start !== 1'b1 && n < 60) begin
      @(negedge clk_1);
      n++;
    end
    chk1("t7_start", bus2.ap_start, 1'b1);
    chk16("t7_r", bus2.r, 16'h0800);
    r_raw = 32'h0002_0000;
    repeat (22) @(negedge clk_1);
    chk1("t7_overrun", overrun2, 1'b1);
    chk16("t7_skip", 16'(skip_cnt2), 16'd1);
    chk16("t7_r_held", bus2.r, 16'h0800);
    chk1("t7_still_busy", busy2, 1'b1);
    repeat (7) @(negedge clk_1);
    bus2.layer13_out = -16'sd100; bus2.ap_done = 1'b1;
    @(negedge clk_1);
    bus2.ap_done = 1'b0;
    chk16("t7_u_cmd", u_cmd2, 16'hFF9C);
    chk1("t7_uvalid", u_valid2, 1'b1);
    chk1("t7_no_timeout", timeout2, 1'b0);
    clear_flags2 = 1'b1;
    @(negedge clk_1);
    clear_flags2 = 1'b0;
    enable2 = 1'b0;
    chk1("t7_overrun_clr", overrun2, 1'b0);
    chk16("t7_skip_clr", 16'(skip_cnt2), 16'd0);

    // T8: reset during BUSY, then a late done must be ignored
    enable = 1'b1;
    wait_start1("t8_start");
    @(negedge clk_1);
    chk1("t8_busy", busy, 1'b1);
    chk16("t8_u_cmd_before", u_cmd, 16'd77);
    chk16("t8_r_before", bus1.r, 16'h0100);
    ap_rst = 1'b1; enable = 1'b0;
    #1;
    chk1("t8_rst_busy", busy, 1'b0);
    chk16("t8_rst_u_cmd", u_cmd, 16'h0000);
    chk16("t8_rst_r", bus1.r, 16'h0000);
    chk1("t8_rst_ap_start", bus1.ap_start, 1'b0);
    repeat (2) @(negedge clk_1);
    ap_rst = 1'b0;
    @(negedge clk_1);
    bus1.layer13_out = 16'sd500; bus1.layer13_out_ap_vld = 1'b1; bus1.ap_done = 1'b1;
    @(negedge clk_1);
    bus1.layer13_out_ap_vld = 1'b0; bus1.ap_done = 1'b0;
    chk1("t8_late_done_no_uvalid", u_valid, 1'b0);
    chk16("t8_late_done_u_cmd", u_cmd, 16'h0000);
    chk1("t8_late_done_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
